noc_input_buffer: RTL and testbench

- Per-port input stage directly upstream of the 5-port NoC router crossbar. One instance per router input; five instances feed the router's flit_in/valid_in/ready_in bundle.
- Buffers incoming 64-bit flits in a small FIFO.
- Tracks packet framing (head/body/tail) and computes dimension-order XY route from head flit.
- Presents flit plus one-hot output-port request to the crossbar, holding that route for the whole packet.

---
 rtl/noc_input_buffer.sv | 220 ++++++++++++++++++++++
 tb/tb_noc_input_buffer.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_input_buffer.sv
// Per-port NoC input stage: FIFO, head/body/tail framing and XY route request. Optional NOC_IBUF_PKTCNT_EN adds pkt_count.
// Latency: a pushed flit reaches out_flit one cycle later at the earliest (no bypass).
// Backpressure: in_ready drops when the FIFO is full; out_flit/out_route hold while out_ready is low.

module noc_ibuf_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_vld,
  input  logic [WIDTH-1:0]         push_dat,
  output logic                     push_rdy,
  output logic                     pop_vld,
  output logic [WIDTH-1:0]         pop_dat,
  input  logic                     pop_rdy,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_fire;
  logic             pop_fire;

  // Full blocks a push even when a pop happens in the same cycle.
  assign push_rdy  = (count < (AW+1)'(DEPTH));
  assign pop_vld   = (count != '0);
  assign pop_dat   = mem[rd_ptr];
  assign push_fire = push_vld && push_rdy;
  assign pop_fire  = pop_vld && pop_rdy;

  always_ff @(posedge clk) begin
    if (push_fire) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_fire) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_fire, pop_fire})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module noc_input_buffer #(
  parameter int DEPTH   = 4,
  parameter int COORD_W = 4,
  parameter int MY_X    = 0,
  parameter int MY_Y    = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [63:0]            in_flit,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [63:0]            out_flit,
  output logic                   out_valid,
  output logic [4:0]             out_route,
  input  logic                   out_ready,
  output logic                   err_proto,
  output logic [$clog2(DEPTH):0] occupancy
`ifdef NOC_IBUF_PKTCNT_EN
  ,
  output logic [15:0]            pkt_count
`endif
);
  typedef enum logic {IDLE, IN_PKT} state_t;

  localparam logic [COORD_W-1:0] MY_X_C = COORD_W'(MY_X);
  localparam logic [COORD_W-1:0] MY_Y_C = COORD_W'(MY_Y);

  localparam logic [4:0] R_LOCAL = 5'b00001;
  localparam logic [4:0] R_NORTH = 5'b00010;
  localparam logic [4:0] R_EAST  = 5'b00100;
  localparam logic [4:0] R_SOUTH = 5'b01000;
  localparam logic [4:0] R_WEST  = 5'b10000;

  state_t             state_q, state_d;
  logic [4:0]         route_q, route_d;
  logic               err_q;
  logic               head_vld;
  logic [63:0]        head_dat;
  logic               fifo_pop;
  logic               fifo_push_rdy;
  logic [1:0]         flit_type;
  logic               starts_pkt;
  logic               ends_pkt;
  logic [COORD_W-1:0] dest_x;
  logic [COORD_W-1:0] dest_y;
  logic [4:0]         calc_route;
  logic               vld_c;
  logic [4:0]         route_c;
  logic               discard;
  logic               err_set;

  assign in_ready = fifo_push_rdy && !rst;

  noc_ibuf_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (in_valid && in_ready),
    .push_dat (in_flit),
    .push_rdy (fifo_push_rdy),
    .pop_vld  (head_vld),
    .pop_dat  (head_dat),
    .pop_rdy  (fifo_pop),
    .count    (occupancy)
  );

  // Type encoding: bit0 marks a packet start (head/single), bit1 a packet end (tail/single).
  assign flit_type  = head_dat[63:62];
  assign starts_pkt = flit_type[0];
  assign ends_pkt   = flit_type[1];
  assign dest_x     = head_dat[61 -: COORD_W];
  assign dest_y     = head_dat[61-COORD_W -: COORD_W];

  always_comb begin
    calc_route = R_LOCAL;
    if (dest_x > MY_X_C) begin
      calc_route = R_EAST;
    end else if (dest_x < MY_X_C) begin
      calc_route = R_WEST;
    end else if (dest_y > MY_Y_C) begin
      calc_route = R_NORTH;
    end else if (dest_y < MY_Y_C) begin
      calc_route = R_SOUTH;
    end
  end

  always_comb begin
    state_d = state_q;
    route_d = route_q;
    vld_c   = 1'b0;
    route_c = 5'b00000;
    discard = 1'b0;
    err_set = 1'b0;
    if (head_vld) begin
      if (starts_pkt) begin
        // A new head while a packet is open is flagged, then handled as a fresh packet.
        vld_c   = 1'b1;
        route_c = calc_route;
        err_set = (state_q == IN_PKT);
        if (out_ready) begin
          if (ends_pkt) begin
            state_d = IDLE;
            route_d = 5'b00000;
          end else begin
            state_d = IN_PKT;
            route_d = calc_route;
          end
        end
      end else if (state_q == IDLE) begin
        discard = 1'b1;
        err_set = 1'b1;
      end else begin
        vld_c   = 1'b1;
        route_c = route_q;
        if (out_ready && ends_pkt) begin
          state_d = IDLE;
          route_d = 5'b00000;
        end
      end
    end
  end

  assign fifo_pop  = (vld_c && out_ready) || discard;
  assign out_valid = vld_c;
  assign out_route = route_c;
  assign out_flit  = vld_c ? head_dat : 64'd0;
  assign err_proto = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      route_q <= 5'b00000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
      if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

`ifdef NOC_IBUF_PKTCNT_EN
  logic [15:0] pkt_cnt_q;
  logic        pkt_done;

  assign pkt_done = vld_c && out_ready && ends_pkt;

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt_q <= 16'd0;
    end else if (pkt_done) begin
      pkt_cnt_q <= pkt_cnt_q + 16'd1;
    end
  end

  assign pkt_count = pkt_cnt_q;
`else
  // Packet counter not built.
`endif
endmodule

// File: tb/tb_noc_input_buffer.sv
// Bench for noc_input_buffer: directed scenarios plus random traffic scored against a packet-level model.
module tb_noc_input_buffer;
  localparam int DEPTH = 4;
  localparam int MY_X  = 1;
  localparam int MY_Y  = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] in_flit = 64'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] out_flit;
  logic        out_valid;
  logic [4:0]  out_route;
  logic        out_ready = 1'b0;
  logic        err_proto;
  logic [2:0]  occupancy;
`ifdef NOC_IBUF_PKTCNT_EN
  logic [15:0] pkt_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  noc_input_buffer #(.DEPTH(DEPTH), .COORD_W(4), .MY_X(MY_X), .MY_Y(MY_Y)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_flit   (in_flit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_flit  (out_flit),
    .out_valid (out_valid),
    .out_route (out_route),
    .out_ready (out_ready),
    .err_proto (err_proto),
    .occupancy (occupancy)
`ifdef NOC_IBUF_PKTCNT_EN
    ,
    .pkt_count (pkt_count)
`endif
  );

  // Observation: accepted input flits, popped output flits, protocol violations.
  logic [63:0] acc_q[$];
  logic [63:0] obs_flit_q[$];
  logic [4:0]  obs_route_q[$];
  int          route_viol = 0;
  int          stab_viol = 0;
  bit          prev_stall = 0;
  bit          prev_rst = 1;
  logic [63:0] prev_flit;
  logic [4:0]  prev_route;

  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) acc_q.push_back(in_flit);
      if (out_valid && out_ready) begin
        obs_flit_q.push_back(out_flit);
        obs_route_q.push_back(out_route);
      end
    end
    if (!out_valid && out_route != 5'b0) route_viol++;
    if (prev_stall && !prev_rst && (!out_valid || out_flit !== prev_flit || out_route !== prev_route))
      stab_viol++;
    prev_stall = out_valid && !out_ready;
    prev_rst   = rst;
    prev_flit  = out_flit;
    prev_route = out_route;
  end

  // Reference model: walk the accepted flits packet by packet.
  logic [63:0] exp_flit_q[$];
  logic [4:0]  exp_route_q[$];
  bit          exp_err;
  int          exp_pkts;

  function automatic logic [4:0] xy_route(input logic [63:0] f);
    int dx = int'(f[61:58]);
    int dy = int'(f[57:54]);
    if (dx > MY_X) return 5'b00100;
    if (dx < MY_X) return 5'b10000;
    if (dy > MY_Y) return 5'b00010;
    if (dy < MY_Y) return 5'b01000;
    return 5'b00001;
  endfunction

  function automatic void build_expected();
    bit         in_pkt = 0;
    logic [4:0] cur = 5'b0;
    logic [1:0] t;
    exp_flit_q.delete();
    exp_route_q.delete();
    exp_err  = 0;
    exp_pkts = 0;
    foreach (acc_q[i]) begin
      t = acc_q[i][63:62];
      if (t == 2'b01 || t == 2'b11) begin
        if (in_pkt) exp_err = 1;
        cur = xy_route(acc_q[i]);
        exp_flit_q.push_back(acc_q[i]);
        exp_route_q.push_back(cur);
        in_pkt = (t == 2'b01);
        if (t == 2'b11) exp_pkts++;
      end else if (!in_pkt) begin
        exp_err = 1;
      end else begin
        exp_flit_q.push_back(acc_q[i]);
        exp_route_q.push_back(cur);
        if (t == 2'b10) begin
          in_pkt = 0;
          exp_pkts++;
        end
      end
    end
  endfunction

  function automatic logic [63:0] mk_flit(input logic [1:0] t, input int dx, input int dy);
    logic [63:0] f;
    f = {t, 4'(dx), 4'(dy), 22'($urandom), $urandom};
    return f;
  endfunction

  task automatic clear_obs();
    acc_q.delete();
    obs_flit_q.delete();
    obs_route_q.delete();
    route_viol = 0;
    stab_viol = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_obs();
  endtask

  task automatic push_flit(input logic [63:0] f);
    int n = 0;
    in_flit = f;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL push_timeout: in_ready stayed %b, required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    in_flit = mk_flit(2'b11, 1, 1);
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    clear_obs();
    @(negedge clk);
    checks++;
    if (occupancy !== 3'd0 || out_valid !== 1'b0 || out_route !== 5'b0 || out_flit !== 64'd0 || err_proto !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: occ=%0d vld=%b route=%b flit=%h err=%b want 0/0/0/0/0",
               occupancy, out_valid, out_route, out_flit, err_proto);
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b want 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic [63:0] f;
    do_reset();
    out_ready = 1'b1;
    f = mk_flit(2'b11, 3, 1);
    in_flit = f;
    in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL single_no_bypass: out_valid=%b want 0", out_valid); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_route !== 5'b00100 || out_flit !== f) begin
      errors++;
      $display("FAIL single_out: vld=%b route=%b flit=%h want 1/00100/%h", out_valid, out_route, out_flit, f);
    end
    @(posedge clk); #1;
    // Stays IDLE: a following body must be dropped and flagged.
    push_flit(mk_flit(2'b00, 1, 1));
    wait_cycles(2);
    checks++;
    if (err_proto !== 1'b1 || obs_flit_q.size() != 1) begin
      errors++;
      $display("FAIL single_idle_after: err=%b popped=%0d want 1/1", err_proto, obs_flit_q.size());
    end
  endtask

  task automatic test_multi();
    do_reset();
    out_ready = 1'b1;
    push_flit(mk_flit(2'b01, 1, 0));
    push_flit(mk_flit(2'b00, 7, 7));
    push_flit(mk_flit(2'b00, 0, 9));
    push_flit(mk_flit(2'b10, 5, 5));
    wait_cycles(3);
    build_expected();
    checks++;
    if (obs_flit_q.size() != 4 || exp_flit_q.size() != 4) begin
      errors++;
      $display("FAIL multi_count: got %0d want 4", obs_flit_q.size());
    end else begin
      foreach (obs_flit_q[i]) begin
        checks++;
        if (obs_flit_q[i] !== exp_flit_q[i] || obs_route_q[i] !== 5'b01000) begin
          errors++;
          $display("FAIL multi_flit%0d: flit=%h route=%b want %h/01000", i, obs_flit_q[i], obs_route_q[i], exp_flit_q[i]);
        end
      end
    end
    checks++;
    if (err_proto !== 1'b0) begin errors++; $display("FAIL multi_err: got %b want 0", err_proto); end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    push_flit(mk_flit(2'b01, 2, 1));
    push_flit(mk_flit(2'b00, 0, 0));
    push_flit(mk_flit(2'b00, 3, 3));
    push_flit(mk_flit(2'b10, 0, 2));
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || occupancy !== 3'd4) begin
      errors++;
      $display("FAIL bp_full: in_ready=%b occ=%0d want 0/4", in_ready, occupancy);
    end
    @(posedge clk); #1;
    in_flit = mk_flit(2'b11, 0, 0);
    in_valid = 1'b1;
    wait_cycles(2);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (occupancy !== 3'd4 || acc_q.size() != 4) begin
      errors++;
      $display("FAIL bp_fifth_ignored: occ=%0d accepted=%0d want 4/4", occupancy, acc_q.size());
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || occupancy !== 3'd3) begin
      errors++;
      $display("FAIL bp_first_pop: in_ready=%b occ=%0d want 1/3", in_ready, occupancy);
    end
    wait_cycles(5);
    build_expected();
    checks++;
    if (obs_flit_q.size() != 4) begin
      errors++;
      $display("FAIL bp_drain_count: got %0d want 4", obs_flit_q.size());
    end else begin
      foreach (obs_flit_q[i]) begin
        checks++;
        if (obs_flit_q[i] !== exp_flit_q[i] || obs_route_q[i] !== 5'b00100) begin
          errors++;
          $display("FAIL bp_order%0d: flit=%h route=%b want %h/00100", i, obs_flit_q[i], obs_route_q[i], exp_flit_q[i]);
        end
      end
    end
    checks++;
    if (stab_viol != 0) begin errors++; $display("FAIL bp_stable: violations=%0d want 0", stab_viol); end
  endtask

  task automatic test_body_idle();
    do_reset();
    out_ready = 1'b1;
    push_flit(mk_flit(2'b00, 2, 2));
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL body_idle_hidden: out_valid=%b want 0", out_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (err_proto !== 1'b1 || occupancy !== 3'd0 || obs_flit_q.size() != 0) begin
      errors++;
      $display("FAIL body_idle_drop: err=%b occ=%0d popped=%0d want 1/0/0", err_proto, occupancy, obs_flit_q.size());
    end
    @(posedge clk); #1;
  endtask

  // Runs straight after test_body_idle so err_proto is already set.
  task automatic test_reset_mid();
    out_ready = 1'b0;
    push_flit(mk_flit(2'b01, 3, 3));
    push_flit(mk_flit(2'b00, 0, 0));
    push_flit(mk_flit(2'b00, 0, 0));
    @(negedge clk);
    checks++;
    if (occupancy !== 3'd3) begin errors++; $display("FAIL rstmid_pre: occ=%0d want 3", occupancy); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_obs();
    @(negedge clk);
    checks++;
    if (occupancy !== 3'd0 || out_valid !== 1'b0 || err_proto !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_clear: occ=%0d vld=%b err=%b want 0/0/0", occupancy, out_valid, err_proto);
    end
    @(posedge clk); #1;
    push_flit(mk_flit(2'b01, MY_X, MY_Y));
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_route !== 5'b00001) begin
      errors++;
      $display("FAIL rstmid_local: vld=%b route=%b want 1/00001", out_valid, out_route);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_head_in_pkt();
    do_reset();
    out_ready = 1'b1;
    push_flit(mk_flit(2'b01, 0, 1));
    push_flit(mk_flit(2'b00, 0, 0));
    push_flit(mk_flit(2'b01, 1, 2));
    push_flit(mk_flit(2'b10, 0, 0));
    push_flit(mk_flit(2'b11, 1, 1));
    wait_cycles(4);
    build_expected();
    checks++;
    if (obs_flit_q.size() != exp_flit_q.size()) begin
      errors++;
      $display("FAIL hip_count: got %0d want %0d", obs_flit_q.size(), exp_flit_q.size());
    end else begin
      foreach (obs_flit_q[i]) begin
        checks++;
        if (obs_flit_q[i] !== exp_flit_q[i] || obs_route_q[i] !== exp_route_q[i]) begin
          errors++;
          $display("FAIL hip_flit%0d: route=%b want %b", i, obs_route_q[i], exp_route_q[i]);
        end
      end
    end
    checks++;
    if (err_proto !== 1'b1) begin errors++; $display("FAIL hip_err: got %b want 1", err_proto); end
  endtask

  task automatic test_random();
    int n = 0;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      in_valid  = ($urandom % 3) != 0;
      in_flit   = mk_flit(2'($urandom), int'($urandom % 3), int'($urandom % 3));
      out_ready = ($urandom % 4) != 0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    while ((occupancy != 3'd0 || out_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 100) begin errors++; $display("FAIL rand_drain_timeout: occ=%0d want 0", occupancy); end
    build_expected();
    checks++;
    if (obs_flit_q.size() != exp_flit_q.size()) begin
      errors++;
      $display("FAIL rand_count: got %0d want %0d", obs_flit_q.size(), exp_flit_q.size());
    end else begin
      foreach (obs_flit_q[i]) begin
        checks++;
        if (obs_flit_q[i] !== exp_flit_q[i] || obs_route_q[i] !== exp_route_q[i]) begin
          errors++;
          $display("FAIL rand_flit%0d: flit=%h route=%b want %h/%b", i, obs_flit_q[i], obs_route_q[i],
                   exp_flit_q[i], exp_route_q[i]);
        end
      end
    end
    checks++;
    if (err_proto !== exp_err) begin errors++; $display("FAIL rand_err: got %b want %b", err_proto, exp_err); end
    checks++;
    if (stab_viol != 0 || route_viol != 0) begin
      errors++;
      $display("FAIL rand_protocol: stability=%0d idle_route=%0d want 0/0", stab_viol, route_viol);
    end
`ifdef NOC_IBUF_PKTCNT_EN
    checks++;
    if (pkt_count !== 16'(exp_pkts)) begin
      errors++;
      $display("FAIL rand_pktcnt: got %0d want %0d", pkt_count, exp_pkts);
    end
`endif
  endtask

`ifdef NOC_IBUF_PKTCNT_EN
  task automatic test_pktcnt();
    do_reset();
    out_ready = 1'b1;
    checks++;
    if (pkt_count !== 16'd0) begin errors++; $display("FAIL pktcnt_reset: got %0d want 0", pkt_count); end
    for (int i = 0; i < 3; i++) push_flit(mk_flit(2'b11, i, 0));
    push_flit(mk_flit(2'b01, 2, 2));
    push_flit(mk_flit(2'b00, 0, 0));
    push_flit(mk_flit(2'b00, 0, 0));
    push_flit(mk_flit(2'b10, 0, 0));
    wait_cycles(3);
    checks++;
    if (pkt_count !== 16'd4) begin errors++; $display("FAIL pktcnt_total: got %0d want 4", pkt_count); end
  endtask
`endif

  initial begin
    wait_cycles(2);
    test_reset();
    test_single();
    test_multi();
    test_backpressure();
    test_body_idle();
    test_reset_mid();
    test_head_in_pkt();
`ifdef NOC_IBUF_PKTCNT_EN
    test_pktcnt();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
